sram_cache_controller: RTL and testbench



---
 rtl/sram_cache_controller.sv | 187 ++++++++++++++++++
 tb/tb_sram_cache_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate read cache placed in
// front of the SRAM controller. Misses fetch a 64-bit block; writes always go to SRAM.
// Optional feature macro: CACHE_STATS_EN adds o_hit_count / o_miss_count outputs.
module sram_cache_controller #(
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int unsigned INDEX_W   = 6
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rd_en,
  input  logic        i_wr_en,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_sram_rd_en,
  output logic        o_sram_wr_en,
  output logic [31:0] o_sram_address,
  output logic [31:0] o_sram_wdata,
  input  logic [63:0] i_sram_rdata,
`ifdef CACHE_STATS_EN
  output logic [31:0] o_hit_count,
  output logic [31:0] o_miss_count,
`endif
  input  logic        i_sram_ready
);

  localparam int unsigned Sets = 1 << INDEX_W;
  localparam int unsigned TagW = 16 - INDEX_W;

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  state_e              r_state;
  logic                r_sram_rd_en;
  logic                r_sram_wr_en;
  logic [Sets-1:0]     r_valid [2];
  logic [Sets-1:0]     r_lru;
  logic [TagW-1:0]     r_tag   [2][Sets];
  logic [63:0]         r_data  [2][Sets];

  logic [31:0]         w_eff;
  logic [INDEX_W-1:0]  w_idx;
  logic [TagW-1:0]     w_tag;
  logic                w_hit0;
  logic                w_hit1;
  logic                w_hit;
  logic                w_hit_way;
  logic                w_victim;
  logic [63:0]         w_hit_blk;
  logic                w_hit_cycle;
  logic                w_fill;
  logic                w_wr_hit;
  logic                w_unused_eff;

  assign w_eff        = i_address - BASE_ADDR;
  assign w_idx        = w_eff[3 +: INDEX_W];
  assign w_tag        = w_eff[18:3+INDEX_W];
  assign w_unused_eff = ^{w_eff[31:19], w_eff[1:0]};

  assign w_hit0    = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
  assign w_hit1    = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
  assign w_hit     = w_hit0 || w_hit1;
  assign w_hit_way = !w_hit0;
  assign w_hit_blk = r_data[w_hit_way][w_idx];

  // Invalid way first (way0 preferred), otherwise the LRU way
  assign w_victim = !r_valid[0][w_idx] ? 1'b0 :
                    !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];

  assign w_hit_cycle = (r_state == StIdle) && i_rd_en && !i_wr_en && w_hit;
  assign w_fill      = (r_state == StRd) && i_sram_ready;
  assign w_wr_hit    = (r_state == StIdle) && i_wr_en && w_hit;

  assign o_sram_address = i_address;
  assign o_sram_wdata   = i_wdata;
  assign o_sram_rd_en   = r_sram_rd_en;
  assign o_sram_wr_en   = r_sram_wr_en;

  // Control FSM; SRAM enables are registered so they are high exactly in RD/WR
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= StIdle;
      r_sram_rd_en <= 1'b0;
      r_sram_wr_en <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_wr_en) begin
            r_state      <= StWr;
            r_sram_wr_en <= 1'b1;
          end else if (i_rd_en && !w_hit) begin
            r_state      <= StRd;
            r_sram_rd_en <= 1'b1;
          end
        end
        StRd: begin
          if (i_sram_ready) begin
            r_state      <= StIdle;
            r_sram_rd_en <= 1'b0;
          end
        end
        StWr: begin
          if (i_sram_ready) begin
            r_state      <= StIdle;
            r_sram_wr_en <= 1'b0;
          end
        end
        default: begin
          r_state      <= StIdle;
          r_sram_rd_en <= 1'b0;
          r_sram_wr_en <= 1'b0;
        end
      endcase
    end
  end

  // Valid and LRU bits; reset invalidates every line
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_valid[0] <= '0;
      r_valid[1] <= '0;
      r_lru      <= '0;
    end else if (w_fill) begin
      r_valid[w_victim][w_idx] <= 1'b1;
      r_lru[w_idx]             <= ~w_victim;
    end else if (w_hit_cycle || w_wr_hit) begin
      r_lru[w_idx] <= ~w_hit_way;
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set
  always_ff @(posedge i_clk) begin
    if (w_fill) begin
      r_tag[w_victim][w_idx]  <= w_tag;
      r_data[w_victim][w_idx] <= i_sram_rdata;
    end else if (w_wr_hit) begin
      if (w_eff[2]) r_data[w_hit_way][w_idx][63:32] <= i_wdata;
      else          r_data[w_hit_way][w_idx][31:0]  <= i_wdata;
    end
  end

  // Combinational handshake: hits and SRAM completions are returned in the same cycle
  always_comb begin
    o_ready = 1'b1;
    o_rdata = '0;
    case (r_state)
      StIdle: begin
        if (i_wr_en) begin
          o_ready = 1'b0;
        end else if (i_rd_en) begin
          o_ready = w_hit;
          if (w_hit) o_rdata = w_eff[2] ? w_hit_blk[63:32] : w_hit_blk[31:0];
        end
      end
      StRd: begin
        o_ready = i_sram_ready;
        if (i_sram_ready) o_rdata = w_eff[2] ? i_sram_rdata[63:32] : i_sram_rdata[31:0];
      end
      StWr: begin
        o_ready = i_sram_ready;
      end
      default: begin
        o_ready = 1'b1;
      end
    endcase
  end

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // One count per read request: at the hit cycle or at the fill edge
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit_cycle) r_hit_count  <= r_hit_count + 32'd1;
      if (w_fill)      r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_sram_cache_controller.sv
// Directed bench for sram_cache_controller: per-cycle vector table plus
// hand-written sequences for eviction, mid-transaction reset and statistics.
module tb_sram_cache_controller;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_tests;
  int n_fail;

  sram_cache_controller dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_rd_en        (rd_en),
    .i_wr_en        (wr_en),
    .i_address      (address),
    .i_wdata        (wdata),
    .o_rdata        (rdata),
    .o_ready        (ready),
    .o_sram_rd_en   (sram_rd_en),
    .o_sram_wr_en   (sram_wr_en),
    .o_sram_address (sram_address),
    .o_sram_wdata   (sram_wdata),
    .i_sram_rdata   (sram_rdata),
`ifdef CACHE_STATS_EN
    .o_hit_count    (hit_count),
    .o_miss_count   (miss_count),
`endif
    .i_sram_ready   (sram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [63:0] srd;
    logic        srdy;
    logic        e_ready;
    logic [31:0] e_rdata;
    logic        e_srd;
    logic        e_swr;
  } vec_t;

  localparam int NVec = 17;
  vec_t vecs [NVec];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [63:0] srd,
                              input logic srdy, input logic e_ready,
                              input logic [31:0] e_rdata, input logic e_srd,
                              input logic e_swr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wd = wd; v.srd = srd; v.srdy = srdy;
    v.e_ready = e_ready; v.e_rdata = e_rdata; v.e_srd = e_srd; v.e_swr = e_swr;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rd_en = 1'b0; wr_en = 1'b0; address = 32'h400; wdata = '0;
    sram_rdata = '0; sram_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One read; on a miss the SRAM answers on the k-th RD cycle
  task automatic do_read(input logic [31:0] a, input logic [63:0] blk, input int k,
                         input logic exp_hit, input string nm);
    logic [31:0] w;
    w = a[2] ? blk[63:32] : blk[31:0];
    @(negedge clk);
    rd_en = 1'b1; address = a;
    #2;
    check({nm, " ready@idle"}, 32'(ready), 32'(exp_hit));
    if (exp_hit) begin
      check({nm, " hit rdata"}, rdata, w);
      check({nm, " hit sram_rd_en"}, 32'(sram_rd_en), 32'd0);
    end else begin
      for (int i = 0; i < k; i++) begin
        @(negedge clk);
        sram_ready = (i == k - 1);
        sram_rdata = blk;
        #2;
        check({nm, " sram_rd_en"}, 32'(sram_rd_en), 32'd1);
        check({nm, " ready@rd"}, 32'(ready), 32'(i == k - 1));
        if (i == k - 1) check({nm, " fill rdata"}, rdata, w);
      end
    end
    @(posedge clk);
    #1;
    rd_en = 1'b0; sram_ready = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    idle_inputs();

    // Vector table: one entry per cycle, starting from a freshly reset cache
    vecs[0]  = mk(1, 0, 32'h400,  0, 64'h0, 0, 0, 32'h0, 0, 0);
    vecs[1]  = mk(1, 0, 32'h400,  0, 64'h0, 0, 0, 32'h0, 1, 0);
    vecs[2]  = mk(1, 0, 32'h400,  0, 64'h22222222_11111111, 1, 1, 32'h11111111, 1, 0);
    vecs[3]  = mk(1, 0, 32'h404,  0, 64'h0, 0, 1, 32'h22222222, 0, 0);
    vecs[4]  = mk(0, 0, 32'h400,  0, 64'h0, 1, 1, 32'h0, 0, 0);
    vecs[5]  = mk(0, 1, 32'h400,  32'hDEADBEEF, 64'h0, 0, 0, 32'h0, 0, 0);
    vecs[6]  = mk(0, 1, 32'h400,  32'hDEADBEEF, 64'h0, 0, 0, 32'h0, 0, 1);
    vecs[7]  = mk(0, 1, 32'h400,  32'hDEADBEEF, 64'h0, 1, 1, 32'h0, 0, 1);
    vecs[8]  = mk(1, 0, 32'h400,  0, 64'h0, 0, 1, 32'hDEADBEEF, 0, 0);
    vecs[9]  = mk(1, 0, 32'h404,  0, 64'h0, 0, 1, 32'h22222222, 0, 0);
    vecs[10] = mk(0, 1, 32'h1000, 32'h12345678, 64'h0, 0, 0, 32'h0, 0, 0);
    vecs[11] = mk(0, 1, 32'h1000, 32'h12345678, 64'h0, 1, 1, 32'h0, 0, 1);
    vecs[12] = mk(1, 0, 32'h1000, 0, 64'h0, 0, 0, 32'h0, 0, 0);
    vecs[13] = mk(1, 0, 32'h1000, 0, 64'hAAAABBBB_CCCCDDDD, 1, 1, 32'hCCCCDDDD, 1, 0);
    vecs[14] = mk(1, 1, 32'h1004, 32'h00000055, 64'h0, 0, 0, 32'h0, 0, 0);
    vecs[15] = mk(1, 1, 32'h1004, 32'h00000055, 64'h0, 1, 1, 32'h0, 0, 1);
    vecs[16] = mk(1, 0, 32'h1004, 0, 64'h0, 0, 1, 32'h00000055, 0, 0);

    // Reset state
    repeat (2) @(negedge clk);
    #2;
    check("reset ready", 32'(ready), 32'd1);
    check("reset rdata", rdata, 32'd0);
    check("reset sram_rd_en", 32'(sram_rd_en), 32'd0);
    check("reset sram_wr_en", 32'(sram_wr_en), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NVec; i++) begin
      @(negedge clk);
      rd_en = vecs[i].rd; wr_en = vecs[i].wr; address = vecs[i].addr;
      wdata = vecs[i].wd; sram_rdata = vecs[i].srd; sram_ready = vecs[i].srdy;
      #2;
      check($sformatf("vec%0d ready", i), 32'(ready), 32'(vecs[i].e_ready));
      check($sformatf("vec%0d rdata", i), rdata, vecs[i].e_rdata);
      check($sformatf("vec%0d sram_rd_en", i), 32'(sram_rd_en), 32'(vecs[i].e_srd));
      check($sformatf("vec%0d sram_wr_en", i), 32'(sram_wr_en), 32'(vecs[i].e_swr));
      check($sformatf("vec%0d sram_address", i), sram_address, vecs[i].addr);
      check($sformatf("vec%0d sram_wdata", i), sram_wdata, vecs[i].wd);
    end

    // LRU eviction in set 0 with the real controller latency (k=6)
    do_reset();
    do_read(32'h400, {32'hA0A0A0A0, 32'h00000400}, 6, 1'b0, "ev 400");
    do_read(32'h600, {32'hA1A1A1A1, 32'h00000600}, 6, 1'b0, "ev 600");
    do_read(32'h800, {32'hA2A2A2A2, 32'h00000800}, 6, 1'b0, "ev 800");
    do_read(32'h600, {32'hA1A1A1A1, 32'h00000600}, 6, 1'b1, "ev 600 hit");
    do_read(32'h804, {32'hA2A2A2A2, 32'h00000800}, 6, 1'b1, "ev 804 hit");
    do_read(32'h400, {32'hA0A0A0A0, 32'h00000400}, 6, 1'b0, "ev 400 again");

    // Reset asserted while a fill is in flight
    do_reset();
    do_read(32'h400, {32'h22222222, 32'h11111111}, 2, 1'b0, "pre 400");
    do_read(32'h404, {32'h22222222, 32'h11111111}, 2, 1'b1, "pre 404 hit");
    @(negedge clk);
    rd_en = 1'b1; address = 32'h808;
    @(negedge clk);
    #2;
    check("midrst sram_rd_en before", 32'(sram_rd_en), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst sram_rd_en after", 32'(sram_rd_en), 32'd0);
    check("midrst sram_wr_en after", 32'(sram_wr_en), 32'd0);
    rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_read(32'h400, {32'h22222222, 32'h11111111}, 2, 1'b0, "post-rst 400");

`ifdef CACHE_STATS_EN
    do_reset();
    check("stats reset hit", hit_count, 32'd0);
    check("stats reset miss", miss_count, 32'd0);
    do_read(32'h400, {32'h22222222, 32'h11111111}, 6, 1'b0, "st 400");
    do_read(32'h404, {32'h22222222, 32'h11111111}, 6, 1'b1, "st 404");
    @(negedge clk);
    check("stats hit_count", hit_count, 32'd1);
    check("stats miss_count", miss_count, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
